// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target register file.
package spi_pkg;

  typedef enum logic {
    S_ADDR = 1'b0,
    S_DATA = 1'b1
  } spi_state_e;

  localparam int RW_BIT = 7;
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 7;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx, input int depth);
    return int'(idx) < depth;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for a small bus; bit 0 additionally gets rise/fall pulses
// from a third delayed copy. The remaining bits use only the synchronised path.
module spi_edge_sync #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic         dly_q,  dly_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    dly_d  = sync_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL[0];
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q[0] & ~dly_q;
  assign fall_o = ~sync_q[0] & dly_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI target with a byte register file: address byte then data byte, LSB first,
// addr[7]=1 writes, addr[7]=0 reads back on MISO.
//
// state  | meaning
// S_ADDR | collecting the address byte (bit_cnt counts sampled bits)
// S_DATA | collecting/returning the data byte for the latched address
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             pclk_i,
  input  logic             prst_i,
  input  logic             sclk_i,
  input  logic             cs_i,
  input  logic             mosi_i,
  output logic             miso_o,
  input  logic [IDX_W-1:0] loc_addr_i,
  output logic [BYTE_W-1:0] loc_rdata_o,
  output logic             wr_stb_o,
  output logic             rd_stb_o,
  output logic [IDX_W-1:0] ev_addr_o,
  output logic [BYTE_W-1:0] ev_data_o,
  output logic             err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0] sync_bus;
  logic       sclk_rise, sclk_fall;
  logic       cs_s, mosi_s;

  // bus order {mosi, cs, sclk}: idle values 0/1/1
  spi_edge_sync #(.W(3), .RST_VAL(3'b011)) u_sync (
    .clk_i  (pclk_i),
    .rst_i  (prst_i),
    .d_i    ({mosi_i, cs_i, sclk_i}),
    .sync_o (sync_bus),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign cs_s   = sync_bus[1];
  assign mosi_s = sync_bus[2];

  spi_state_e        state_q,   state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q,   shift_d;
  logic [BYTE_W-1:0] addr_q,    addr_d;
  logic [BYTE_W-1:0] tx_q,      tx_d;
  logic              miso_q,    miso_d;
  logic              wr_stb_q,  wr_stb_d;
  logic              rd_stb_q,  rd_stb_d;
  logic              err_q,     err_d;
  logic [IDX_W-1:0]  ev_addr_q, ev_addr_d;
  logic [BYTE_W-1:0] ev_data_q, ev_data_d;
  logic [TW-1:0]     tmo_q,     tmo_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];

  logic [BYTE_W-1:0] byte_in;
  logic [BYTE_W-1:0] rd_val;
  logic [IDX_W-1:0]  new_idx, cur_idx;
  logic              partial;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    mem_d     = mem_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    err_d     = 1'b0;
    ev_addr_d = ev_addr_q;
    ev_data_d = ev_data_q;
    tmo_d     = TMO_LOAD;
    rd_val    = '0;

    byte_in            = shift_q;
    byte_in[bit_cnt_q] = mosi_s;
    new_idx            = byte_in[IDX_W-1:0];
    cur_idx            = addr_q[IDX_W-1:0];
    partial            = (state_q == S_DATA) || (bit_cnt_q != 3'd0);

    if (cs_s) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
    end else if (sclk_fall) begin
      shift_d   = byte_in;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (state_q == S_ADDR) begin
          addr_d  = byte_in;
          state_d = S_DATA;
          if (!byte_in[RW_BIT]) begin
            if (idx_ok(new_idx, DEPTH)) rd_val = mem_q[new_idx[AW-1:0]];
            else                        err_d  = 1'b1;
            tx_d      = rd_val;
            miso_d    = rd_val[0];
            rd_stb_d  = 1'b1;
            ev_addr_d = new_idx;
            ev_data_d = rd_val;
          end
        end else begin
          state_d = S_ADDR;
          miso_d  = 1'b1;
          if (addr_q[RW_BIT]) begin
            if (idx_ok(cur_idx, DEPTH)) begin
              mem_d[cur_idx[AW-1:0]] = byte_in;
              wr_stb_d  = 1'b1;
              ev_addr_d = cur_idx;
              ev_data_d = byte_in;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end else if ((state_q == S_DATA) && !addr_q[RW_BIT]) begin
        // Bit 0 already went out after the address byte, so stay one bit ahead.
        miso_d = tx_q[bit_cnt_q + 3'd1];
      end
    end else if (partial && !sclk_rise) begin
      if (tmo_q == '0) begin
        state_d   = S_ADDR;
        bit_cnt_d = 3'd0;
        miso_d    = 1'b1;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q   <= S_ADDR;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b1;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      ev_addr_q <= '0;
      ev_data_q <= '0;
      tmo_q     <= TMO_LOAD;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      ev_addr_q <= ev_addr_d;
      ev_data_q <= ev_data_d;
      tmo_q     <= tmo_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    loc_rdata_o = '0;
    if (idx_ok(loc_addr_i, DEPTH)) loc_rdata_o = mem_q[loc_addr_i[AW-1:0]];
  end

  assign miso_o    = miso_q;
  assign wr_stb_o  = wr_stb_q;
  assign rd_stb_o  = rd_stb_q;
  assign err_o     = err_q;
  assign ev_addr_o = ev_addr_q;
  assign ev_data_o = ev_data_q;

endmodule
